// File: rtl/clock_ratio_meter_pkg.sv
// Shared types and constants for the clock ratio meter: FSM states, counter saturation
// value and averaging depth.
package clock_ratio_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } meter_state_e;

    localparam int unsigned AVG_DEPTH = 4;
    localparam int unsigned AVG_SHIFT = 2;

    // All-ones value of the (width+1)-bit period counter.
    function automatic int unsigned sat_value(input int unsigned width);
        return (32'd1 << (width + 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/clock_ratio_meter_if.sv
// Control and result bundle of the clock ratio meter; master is the meter itself,
// slave is the block that drives the clock under test and consumes the results.
interface clock_ratio_meter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic             sig_in;
    logic [WIDTH:0]   period;
    logic [WIDTH:0]   high_time;
    logic [WIDTH-1:0] div_est;
    logic             valid;
    logic             locked;
    logic             timeout;
    logic             range_err;

    modport master (
        input  enable, sig_in,
        output period, high_time, div_est, valid, locked, timeout, range_err
    );

    modport slave (
        output enable, sig_in,
        input  period, high_time, div_est, valid, locked, timeout, range_err
    );
endinterface

// File: rtl/clock_ratio_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level with single-cycle rise/fall pulses
// in the destination clock domain.
module sync_edge_detect #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_async,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_async};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_c = sync_q[STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures period, high time and equivalent divisor of an asynchronous clock in clk_in
// cycles. Define CLOCK_RATIO_METER_AVG_EN to report the average of every 4 periods.
module clock_ratio_meter
    import clock_ratio_meter_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_in,
    input  logic                reset,
    clock_ratio_meter_if.master bus
);

    localparam int unsigned   CW         = WIDTH + 1;
    localparam logic [CW-1:0] SAT        = CW'(sat_value(WIDTH));
    localparam logic [CW-1:0] MAX_PERIOD = CW'(32'd1 << WIDTH);

    meter_state_e     state_q, state_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [CW-1:0]    hcnt_q, hcnt_nxt;
    logic             fall_seen_q, fall_seen_nxt;
    logic [CW-1:0]    last_raw_q, last_raw_nxt;
    logic             have_last_q, have_last_nxt;
    logic [CW-1:0]    period_q, period_nxt;
    logic [CW-1:0]    high_q, high_nxt;
    logic [WIDTH-1:0] div_q, div_nxt;
    logic             valid_q, valid_nxt;
    logic             locked_q, locked_nxt;
    logic             timeout_q, timeout_nxt;
    logic             range_q, range_nxt;
    logic [CW-1:0]    meas_high_c;
    logic             rise_c, fall_c;

`ifdef CLOCK_RATIO_METER_AVG_EN
    localparam int unsigned AW = WIDTH + 3;
    localparam int unsigned PW = $clog2(AVG_DEPTH);

    logic [AW-1:0] acc_q, acc_nxt;
    logic [AW-1:0] hacc_q, hacc_nxt;
    logic [PW-1:0] phase_q, phase_nxt;
    logic [AW-1:0] sum_c, hsum_c;
    logic [CW-1:0] avg_c;
`endif

    function automatic logic out_of_range(input logic [CW-1:0] p);
        return (p < CW'(2)) || (p > MAX_PERIOD);
    endfunction

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in    (clk_in),
        .reset     (reset),
        .sig_async (bus.sig_in),
        .rise_c    (rise_c),
        .fall_c    (fall_c)
    );

    // Next-state and next-value logic for the FSM and its measurement registers.
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        hcnt_nxt      = hcnt_q;
        fall_seen_nxt = fall_seen_q;
        last_raw_nxt  = last_raw_q;
        have_last_nxt = have_last_q;
        period_nxt    = period_q;
        high_nxt      = high_q;
        div_nxt       = div_q;
        valid_nxt     = 1'b0;
        locked_nxt    = locked_q;
        timeout_nxt   = timeout_q;
        range_nxt     = range_q;
        meas_high_c   = fall_seen_q ? hcnt_q : cnt_q;
`ifdef CLOCK_RATIO_METER_AVG_EN
        acc_nxt   = acc_q;
        hacc_nxt  = hacc_q;
        phase_nxt = phase_q;
        sum_c     = acc_q + AW'(cnt_q);
        hsum_c    = hacc_q + AW'(meas_high_c);
        avg_c     = CW'(sum_c >> AVG_SHIFT);
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (rise_c) begin
                    cnt_nxt       = CW'(1);
                    hcnt_nxt      = '0;
                    fall_seen_nxt = 1'b0;
                    timeout_nxt   = 1'b0;
                    state_nxt     = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // A rise in the saturation cycle still closes the measurement.
                if (rise_c) begin
                    cnt_nxt       = CW'(1);
                    hcnt_nxt      = '0;
                    fall_seen_nxt = 1'b0;
                    locked_nxt    = have_last_q && (cnt_q == last_raw_q);
                    last_raw_nxt  = cnt_q;
                    have_last_nxt = 1'b1;
`ifdef CLOCK_RATIO_METER_AVG_EN
                    if (phase_q == PW'(AVG_DEPTH - 1)) begin
                        period_nxt = avg_c;
                        high_nxt   = CW'(hsum_c >> AVG_SHIFT);
                        div_nxt    = WIDTH'(avg_c - CW'(1));
                        valid_nxt  = 1'b1;
                        range_nxt  = out_of_range(avg_c);
                        acc_nxt    = '0;
                        hacc_nxt   = '0;
                        phase_nxt  = '0;
                    end else begin
                        acc_nxt    = sum_c;
                        hacc_nxt   = hsum_c;
                        phase_nxt  = phase_q + PW'(1);
                    end
`else
                    period_nxt = cnt_q;
                    high_nxt   = meas_high_c;
                    div_nxt    = WIDTH'(cnt_q - CW'(1));
                    valid_nxt  = 1'b1;
                    range_nxt  = out_of_range(cnt_q);
`endif
                end else if (cnt_q == SAT) begin
                    timeout_nxt   = 1'b1;
                    locked_nxt    = 1'b0;
                    have_last_nxt = 1'b0;
                    cnt_nxt       = '0;
                    hcnt_nxt      = '0;
                    fall_seen_nxt = 1'b0;
                    state_nxt     = ST_ARM;
`ifdef CLOCK_RATIO_METER_AVG_EN
                    acc_nxt   = '0;
                    hacc_nxt  = '0;
                    phase_nxt = '0;
`endif
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                    if (fall_c) begin
                        hcnt_nxt      = cnt_q;
                        fall_seen_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Disable overrides everything; results keep their last values.
        if (!bus.enable) begin
            state_nxt     = ST_IDLE;
            cnt_nxt       = '0;
            hcnt_nxt      = '0;
            fall_seen_nxt = 1'b0;
            have_last_nxt = 1'b0;
            valid_nxt     = 1'b0;
            locked_nxt    = 1'b0;
            timeout_nxt   = 1'b0;
            range_nxt     = 1'b0;
`ifdef CLOCK_RATIO_METER_AVG_EN
            acc_nxt   = '0;
            hacc_nxt  = '0;
            phase_nxt = '0;
`endif
        end
    end

    // State and measurement registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            fall_seen_q <= 1'b0;
            last_raw_q  <= '0;
            have_last_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            div_q       <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            range_q     <= 1'b0;
`ifdef CLOCK_RATIO_METER_AVG_EN
            acc_q   <= '0;
            hacc_q  <= '0;
            phase_q <= '0;
`endif
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            hcnt_q      <= hcnt_nxt;
            fall_seen_q <= fall_seen_nxt;
            last_raw_q  <= last_raw_nxt;
            have_last_q <= have_last_nxt;
            period_q    <= period_nxt;
            high_q      <= high_nxt;
            div_q       <= div_nxt;
            valid_q     <= valid_nxt;
            locked_q    <= locked_nxt;
            timeout_q   <= timeout_nxt;
            range_q     <= range_nxt;
`ifdef CLOCK_RATIO_METER_AVG_EN
            acc_q   <= acc_nxt;
            hacc_q  <= hacc_nxt;
            phase_q <= phase_nxt;
`endif
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign bus.div_est   = div_q;
    assign bus.valid     = valid_q;
    assign bus.locked    = locked_q;
    assign bus.timeout   = timeout_q;
    assign bus.range_err = range_q;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Bench for clock_ratio_meter: drives sig_in waveforms and predicts each measurement
// from the driven edge timestamps.
module tb_clock_ratio_meter;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned SAT         = (1 << (WIDTH + 1)) - 1;

    logic        clk_in = 1'b0;
    logic        reset;
    int unsigned cyc    = 0;
    int unsigned n_cmp  = 0;
    int unsigned n_err  = 0;

    clock_ratio_meter_if #(.WIDTH(WIDTH)) bus ();

    clock_ratio_meter #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        int unsigned period;
        int unsigned high;
        bit          locked;
        bit          range;
    } meas_t;

    meas_t       exp_q[$];
    meas_t       mon_m;
    bit          level;
    bit          armed;
    bit          have_prev;
    bit          fall_seen;
    int unsigned last_rise;
    int unsigned last_fall;
    int unsigned prev_period;
    int unsigned last_period;
    int unsigned hi;
    int unsigned lo;
    int unsigned r;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        armed     = 1'b0;
        have_prev = 1'b0;
        fall_seen = 1'b0;
    endfunction

    // A rise closes the interval opened by the previous rise, unless that gap
    // outlasted the counter, in which case the meter re-arms on it instead.
    function automatic void model_rise(input int unsigned c);
        int unsigned gap;
        meas_t       m;
        if (armed) begin
            gap = c - last_rise;
            if (gap > SAT) begin
                have_prev = 1'b0;
            end else begin
                m.cyc    = c + SYNC_STAGES + 1;
                m.period = gap;
                m.high   = fall_seen ? (last_fall - last_rise) : gap;
                m.locked = have_prev && (gap == prev_period);
                m.range  = (gap < 2) || (gap > (1 << WIDTH));
                exp_q.push_back(m);
                prev_period = gap;
                have_prev   = 1'b1;
                last_period = gap;
            end
        end
        armed     = 1'b1;
        last_rise = c;
        fall_seen = 1'b0;
    endfunction

    task automatic drive(input bit v, input int unsigned n);
        if (v && !level) begin
            model_rise(cyc);
        end else if (!v && level && armed) begin
            fall_seen = 1'b1;
            last_fall = cyc;
        end
        level      = v;
        bus.sig_in = v;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pulse(input int unsigned h, input int unsigned l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic wait_to(input int unsigned target);
        while (cyc < target) @(negedge clk_in);
    endtask

    task automatic check_all_zero(input string where);
        check_eq({where, "_period"},    32'(bus.period),    32'd0);
        check_eq({where, "_high_time"}, 32'(bus.high_time), 32'd0);
        check_eq({where, "_div_est"},   32'(bus.div_est),   32'd0);
        check_eq({where, "_valid"},     32'(bus.valid),     32'd0);
        check_eq({where, "_locked"},    32'(bus.locked),    32'd0);
        check_eq({where, "_timeout"},   32'(bus.timeout),   32'd0);
        check_eq({where, "_range_err"}, 32'(bus.range_err), 32'd0);
    endtask

    // Every valid must match the oldest prediction, on its predicted cycle.
    always @(negedge clk_in) begin
        if (!reset) begin
            if (bus.valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 32'(bus.valid), 32'd0);
                end else begin
                    mon_m = exp_q.pop_front();
                    check_eq("valid_cycle", cyc, mon_m.cyc);
                    check_eq("period",      32'(bus.period),    mon_m.period);
                    check_eq("high_time",   32'(bus.high_time), mon_m.high);
                    check_eq("div_est",     32'(bus.div_est),   (mon_m.period - 1) % (1 << WIDTH));
                    check_eq("locked",      32'(bus.locked),    32'(mon_m.locked));
                    check_eq("range_err",   32'(bus.range_err), 32'(mon_m.range));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                check_eq("missed_valid", 32'(bus.valid), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.sig_in = 1'b0;
        level      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        check_all_zero("reset");
        reset      = 1'b0;
        bus.enable = 1'b1;
        repeat (4) @(negedge clk_in);

        // Period 5, high 3
        repeat (6) pulse(3, 2);
        check_eq("locked_p5", 32'(bus.locked), 32'd1);

        // Divider at div_num 6: period 7, high 3 or 4
        repeat (3) pulse(3, 4);
        repeat (3) pulse(4, 3);

        // Period change 8 -> 9
        repeat (3) pulse(4, 4);
        repeat (3) pulse(4, 5);

        // Out-of-range periods, including the largest one that is still measured
        pulse(150, 150);
        pulse(200, 311);
        repeat (4) pulse(3, 2);

        // Loss of clock after lock
        drive(1'b1, 3);
        r = last_rise;
        drive(1'b0, 0);
        wait_to(r + 513);
        check_eq("pre_timeout",        32'(bus.timeout), 32'd0);
        check_eq("pre_timeout_locked", 32'(bus.locked),  32'd1);
        wait_to(r + 514);
        check_eq("timeout",            32'(bus.timeout), 32'd1);
        check_eq("timeout_locked",     32'(bus.locked),  32'd0);
        wait_to(r + 600);
        pulse(3, 2);
        check_eq("timeout_cleared",    32'(bus.timeout), 32'd0);
        repeat (3) pulse(3, 2);

        // Asynchronous reset in the middle of a period
        drive(1'b1, 3);
        drive(1'b0, 1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
        repeat (4) pulse(3, 2);

        // Disable after an out-of-range measurement
        repeat (2) pulse(3, 2);
        pulse(150, 150);
        drive(1'b1, 3);
        drive(1'b0, 4);
        check_eq("pre_idle_range", 32'(bus.range_err), 32'd1);
        bus.enable = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_eq("idle_range",   32'(bus.range_err), 32'd0);
        check_eq("idle_timeout", 32'(bus.timeout),   32'd0);
        check_eq("idle_locked",  32'(bus.locked),    32'd0);
        check_eq("idle_period",  32'(bus.period),    last_period);
        bus.enable = 1'b1;
        repeat (3) @(negedge clk_in);

        // Randomized waveforms, often repeating a period so lock can form
        hi = 3;
        lo = 3;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                hi = $urandom_range(2, 6);
                lo = $urandom_range(2, 8);
            end
            pulse(hi, lo);
        end

        repeat (8) @(negedge clk_in);
        check_eq("drain_queue", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
